// File: rtl/demux_1to4_dispatch_if.sv
// Handshake bundle between an upstream producer, the 1-to-4 dispatcher and
// its four consumers.
//   master : producer/consumer side (drives in_*, rr_mode, out_ready)
//   slave  : dispatcher side (drives in_ready, out_*, cur_dst, stall_flag)
interface demux_1to4_dispatch_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          rr_mode;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    cur_dst;
  logic          stall_flag;

  modport master (
    output in_valid, in_data, in_sel, rr_mode, out_ready,
    input  in_ready, out_valid, out_data, cur_dst, stall_flag
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_mode, out_ready,
    output in_ready, out_valid, out_data, cur_dst, stall_flag
  );
endinterface

// File: rtl/demux_1to4_dispatch.sv
// Single-entry handshaked dispatcher feeding one of four consumers.
// A word accepted on in_valid/in_ready is held and offered (one-hot
// out_valid) to the consumer picked by in_sel (directed) or by an internal
// round-robin pointer (rr_mode=1). stall_flag rises when the held word has
// waited STALL_MAX cycles without being taken.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dispatcher side of demux_1to4_dispatch_if (slave modport)
module demux_1to4_dispatch #(
  parameter int DW        = 8,
  parameter int STALL_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demux_1to4_dispatch_if.slave     bus
);

  localparam int CW = $clog2(STALL_MAX + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_reg;
  logic [DW-1:0] data_reg;
  logic [1:0]    dst_reg;
  logic [1:0]    rr_ptr_reg;
  logic [3:0]    out_valid_reg;
  logic [CW-1:0] stall_cnt_reg;

  logic       deliver;
  logic       in_ready;
  logic       accept;
  logic [1:0] dst_next;

  // Deliver and accept may happen in the same cycle: the ready of the
  // current destination frees the register combinationally, giving full
  // back-to-back throughput.
  assign deliver  = (state_reg == HOLD) && bus.out_ready[dst_reg];
  assign in_ready = (state_reg == IDLE) || deliver;
  assign accept   = bus.in_valid && in_ready;
  assign dst_next = bus.rr_mode ? rr_ptr_reg : bus.in_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      dst_reg       <= 2'd0;
      rr_ptr_reg    <= 2'd0;
      out_valid_reg <= 4'b0000;
      stall_cnt_reg <= '0;
    end else begin
      if (accept) begin
        state_reg     <= HOLD;
        data_reg      <= bus.in_data;
        dst_reg       <= dst_next;
        out_valid_reg <= 4'b0001 << dst_next;
        stall_cnt_reg <= '0;
        // 2-bit pointer wraps 3 -> 0 naturally
        if (bus.rr_mode) begin
          rr_ptr_reg <= rr_ptr_reg + 2'd1;
        end
      end else if (deliver) begin
        state_reg     <= IDLE;
        out_valid_reg <= 4'b0000;
        stall_cnt_reg <= '0;
      end else if ((state_reg == HOLD) && (stall_cnt_reg != CW'(STALL_MAX))) begin
        stall_cnt_reg <= stall_cnt_reg + CW'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = data_reg;
  assign bus.cur_dst    = dst_reg;
  assign bus.stall_flag = (stall_cnt_reg == CW'(STALL_MAX));

endmodule

// File: tb/tb_demux_1to4_dispatch.sv
module tb_demux_1to4_dispatch;

  localparam int DW        = 8;
  localparam int STALL_MAX = 15;

  logic clk;
  logic rst_n;

  demux_1to4_dispatch_if #(.DW(DW)) bus ();

  demux_1to4_dispatch #(.DW(DW), .STALL_MAX(STALL_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one optional held word plus a destination pointer and
  // a count of cycles the word has waited.
  bit       m_full;
  bit [7:0] m_data;
  int       m_dst;
  int       m_rr;
  int       m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input logic [3:0] ordy);
    return !m_full || (ordy[m_dst] == 1'b1);
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = 8'h00; m_dst = 0; m_rr = 0; m_wait = 0;
  endtask

  task automatic model_edge();
    bit acc, dlv;
    acc = bus.in_valid && m_ready(bus.out_ready);
    dlv = m_full && bus.out_ready[m_dst];
    if (dlv) $display("deliver data=%02h dst=%0d", m_data, m_dst);
    if (acc) begin
      m_data = bus.in_data;
      m_dst  = bus.rr_mode ? m_rr : int'(bus.in_sel);
      if (bus.rr_mode) m_rr = (m_rr + 1) % 4;
      m_full = 1; m_wait = 0;
    end else if (dlv) begin
      m_full = 0; m_wait = 0;
    end else if (m_full && m_wait < STALL_MAX) begin
      m_wait++;
    end
  endtask

  task automatic check_model();
    chk("out_valid", bus.out_valid, m_full ? (32'd1 << m_dst) : 32'd0);
    chk("out_data", bus.out_data, m_data);
    chk("cur_dst", bus.cur_dst, m_dst);
    chk("stall_flag", bus.stall_flag, (m_full && m_wait == STALL_MAX) ? 1 : 0);
  endtask

  // One clock: drive inputs, check in_ready before the edge, advance the
  // model at the edge, check outputs 1 time unit later.
  task automatic step(input bit v, input logic [7:0] d, input logic [1:0] s,
                      input bit rr, input logic [3:0] ordy);
    bus.in_valid = v; bus.in_data = d; bus.in_sel = s;
    bus.rr_mode = rr; bus.out_ready = ordy;
    #1;
    chk("in_ready", bus.in_ready, m_ready(ordy));
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic [1:0] s;
    bit         rr;
    logic [3:0] ordy;
    logic [3:0] exp_ov;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // directed: A5 to 2, then sweep sel 0..3 back to back
    vecs[0] = '{1, 8'hA5, 2'd2, 0, 4'b1111, 4'b0100, 8'hA5};
    vecs[1] = '{1, 8'h01, 2'd0, 0, 4'b1111, 4'b0001, 8'h01};
    vecs[2] = '{1, 8'h01, 2'd1, 0, 4'b1111, 4'b0010, 8'h01};
    vecs[3] = '{1, 8'h01, 2'd2, 0, 4'b1111, 4'b0100, 8'h01};
    vecs[4] = '{1, 8'h01, 2'd3, 0, 4'b1111, 4'b1000, 8'h01};
    // round-robin: words 1..5, in_sel ignored
    vecs[5] = '{1, 8'h01, 2'd0, 1, 4'b1111, 4'b0001, 8'h01};
    vecs[6] = '{1, 8'h02, 2'd0, 1, 4'b1111, 4'b0010, 8'h02};
    vecs[7] = '{1, 8'h03, 2'd0, 1, 4'b1111, 4'b0100, 8'h03};
    vecs[8] = '{1, 8'h04, 2'd0, 1, 4'b1111, 4'b1000, 8'h04};
    vecs[9] = '{1, 8'h05, 2'd0, 1, 4'b1111, 4'b0001, 8'h05};

    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_data = 0; bus.in_sel = 0;
    bus.rr_mode = 0; bus.out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 4'b0000);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_stall", bus.stall_flag, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].rr, vecs[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].exp_ov);
      chk($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].exp_d);
      $display("vec %0d data=%02h out_valid=%b", i, bus.out_data, bus.out_valid);
    end

    // async reset mid-HOLD: rr_ptr is 1 now, register is full
    step(0, 8'h00, 2'd0, 0, 4'b0000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", bus.out_valid, 4'b0000);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    chk("arst_out_data", bus.out_data, 8'h00);
    chk("arst_cur_dst", bus.cur_dst, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h11, 2'd3, 1, 4'b0000);
    chk("arst_rr_ptr0", bus.cur_dst, 2'd0);
    $display("async reset: rr word to dst=%0d", bus.cur_dst);
    step(0, 8'h00, 2'd0, 0, 4'b1111);

    // backpressure on dst 1, then delivery+load in one cycle
    step(1, 8'h3C, 2'd1, 0, 4'b1101);
    step(1, 8'h77, 2'd2, 0, 4'b1101);
    chk("bp_out_valid", bus.out_valid, 4'b0010);
    chk("bp_out_data", bus.out_data, 8'h3C);
    bus.out_ready = 4'b1111;
    #1;
    chk("bp_in_ready_up", bus.in_ready, 1'b1);
    step(1, 8'h77, 2'd2, 0, 4'b1111);
    chk("bp_reload_valid", bus.out_valid, 4'b0100);
    chk("bp_reload_data", bus.out_data, 8'h77);
    $display("backpressure: reload data=%02h out_valid=%b", bus.out_data, bus.out_valid);

    // stall: 20 cycles with no ready; flag from the 15th
    for (int k = 1; k <= 20; k++) begin
      step(0, 8'h00, 2'd0, 0, 4'b0000);
      chk($sformatf("stall_c%0d", k), bus.stall_flag, (k >= STALL_MAX) ? 1'b1 : 1'b0);
    end
    chk("stall_word_kept", bus.out_data, 8'h77);
    step(0, 8'h00, 2'd0, 0, 4'b0100);
    chk("stall_release_flag", bus.stall_flag, 1'b0);
    chk("stall_release_valid", bus.out_valid, 4'b0000);
    $display("stall: released, out_valid=%b", bus.out_valid);

    // mode/sel change while holding does not move the destination
    step(1, 8'h5A, 2'd3, 0, 4'b0000);
    step(1, 8'h66, 2'd0, 1, 4'b0111);
    chk("mode_hold_dst", bus.cur_dst, 2'd3);
    step(1, 8'h66, 2'd1, 0, 4'b0111);
    chk("mode_hold_dst2", bus.cur_dst, 2'd3);
    step(0, 8'h00, 2'd1, 1, 4'b1000);
    chk("mode_deliver", bus.out_valid, 4'b0000);
    $display("mode change: delivered to dst 3");

    // randomized traffic with varying consumer readiness
    for (int blk = 0; blk < 12; blk++) begin
      int pr;
      pr = (blk % 3 == 0) ? 5 : $urandom_range(20, 95);
      for (int c = 0; c < 60; c++) begin
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 99) < pr);
        step($urandom_range(0, 99) < 70, 8'($urandom), 2'($urandom),
             $urandom_range(0, 1) == 1, r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
